vga_term_ctrl: RTL
==================

// Module: vga_term_ctrl
// PURPOSE
// - Write-side controller for the VGA text terminal's character buffer (term_w x term_h cells, 8-bit codes).
// - Accepts a byte stream from the CPU/MMIO side over a valid/ready handshake.
// - Tracks the cursor, interprets control codes, performs line wrap and hardware scroll, and issues one RAM write per cycle.
// - scroll_base goes to the display side: physical cell = (scroll_base + charidx) mod N, where N = term_w*term_h.
// PARAMETERS
// term_w  70     columns per line
// term_h  30     lines per screen; N = term_w*term_h must be <= 4096
// blank   8'h20  fill code used for clears
// PORTS
// clk_50M      in   1   system clock; all logic on posedge
// rst_n        in   1   asynchronous reset, active-low
// in_valid     in   1   in_char is valid
// in_char      in   8   character/control byte
// in_ready     out  1   byte accepted on the cycle in_valid && in_ready
// clr          in   1   clear-screen request, single-cycle pulse
// wr_en        out  1   char-buffer write strobe
// wr_addr      out  12  physical buffer address, 0..N-1
// wr_data      out  8   code to write
// scroll_base  out  12  physical index of the top displayed line start
// cur_row      out  5   cursor line, 0..term_h-1
// cur_col      out  7   cursor column, 0..term_w-1
// busy         out  1   FSM is not in IDLE
// BEHAVIOUR
// - Reset: wr_en=0, wr_addr=0, wr_data=blank, scroll_base=0, cur_row=0, cur_col=0, state=CLR_ALL.
//   busy=1 and in_ready=0 until the power-on clear finishes.
// - States:
//   IDLE: accept bytes.
//   CLR_LINE: write blank to term_w cells, one per cycle, then go to IDLE.
//   CLR_ALL: write blank to N cells at addresses 0..N-1, then cur=(0,0), scroll_base=0, go to IDLE.
//   TAB (macro only): see CONFIGURATION.
// - in_ready = (state==IDLE) && !clr. A clr pulse in IDLE wins over a simultaneous in_valid: the byte is not taken. clr outside IDLE is ignored.
// - All write outputs are registered. A byte accepted in cycle t produces wr_en=1 in cycle t+1.
//   Printable bytes sustain 1 byte/cycle.
// - Cursor physical address is kept as line_addr + cur_col, with line_addr = (scroll_base + cur_row*term_w) mod N.
//   line_addr is maintained incrementally, with no multiplier; every add wraps modulo N.
// - Byte 0x20..0x7E: write to (cur_row, cur_col).
//   If cur_col < term_w-1: cur_col+1.
//   Else: perform a NEWLINE action.
// - 0x0A NEWLINE: cur_col=0.
//   If cur_row < term_h-1: cur_row+1.
//   Else: cur_row stays; scroll_base += term_w (mod N); enter CLR_LINE on the new bottom line, i.e. the old top line's physical cells.
// - 0x0D: cur_col=0. No write.
// - 0x08: if cur_col>0 then cur_col-1. No erase, no write.
// - All other bytes (and 0x7F): dropped. in_ready handshake completes; no state change.
// - Scroll timing: scroll_base updates on the same edge that enters CLR_LINE. CLR_LINE lasts exactly term_w cycles of wr_en=1, then 1 cycle back to IDLE.
// - Boundaries:
//   - Wrap and NEWLINE at the last line scroll identically.
//   - scroll_base wraps N-term_w -> 0.
//   - Addresses never reach N.
//   - Async reset mid-CLR aborts the clear and restarts CLR_ALL.
// CONFIGURATION
// - TERM_TAB_EN defined:
//   - 0x09 enters TAB.
//   - TAB writes blank at the cursor and advances as a printable byte would, repeating each cycle until cur_col is a multiple of 8 (at least one cell).
//   - Wrap/scroll rules apply; a wrap ends TAB with cur_col=0.
//   - in_ready=0 during TAB.
// - Undefined: 0x09 is dropped like any other control byte, and the TAB state does not exist.
// TESTING
// - Release rst_n: 2100 writes of 0x20 to addrs 0..2099, then in_ready=1, cur=(0,0), scroll_base=0.
// - Send "AB" back-to-back: writes (0,'A'),(1,'B') on consecutive cycles; cur_col=2.
// - Send 70 'x' on row 0: last write at addr 69; cur=(1,0); no CLR_LINE.
// - At cur_row=29, send 0x0A: scroll_base=70; 70 writes of 0x20 at addrs 0..69; cur=(29,0).
//   Repeat 30 times: scroll_base wraps to 0.
// - clr and in_valid('Z') in the same IDLE cycle: 'Z' is not accepted; full clear; then 'Z' is written at addr 0.
// - TERM_TAB_EN: cur_col=3, send 0x09: blanks at cols 3..7, cur_col=8. Without the macro: no write, cur_col=3.

Source files
------------

// File: rtl/vga_term_ctrl.sv
// Write-side controller for the VGA text terminal character buffer: cursor, control codes, wrap, scroll, clears.
// Optional macro TERM_TAB_EN adds the TAB state (0x09 blanks up to the next multiple-of-8 column).
module vga_term_ctrl #(
  parameter int         term_w = 70,
  parameter int         term_h = 30,
  parameter logic [7:0] blank  = 8'h20
) (
  input  logic        clk_50M,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  input  logic        clr,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [11:0] scroll_base,
  output logic [4:0]  cur_row,
  output logic [6:0]  cur_col,
  output logic        busy
);

  localparam int          N       = term_w * term_h;
  localparam logic [11:0] N_M1    = 12'(N - 1);
  localparam logic [11:0] W_A     = 12'(term_w);
  localparam logic [6:0]  COL_MAX = 7'(term_w - 1);
  localparam logic [4:0]  ROW_MAX = 5'(term_h - 1);

`ifdef TERM_TAB_EN
  typedef enum logic [1:0] {ST_IDLE, ST_CLR_LINE, ST_CLR_ALL, ST_TAB} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_CLR_LINE, ST_CLR_ALL} state_t;
`endif

  state_t      state_q, state_d;
  logic [11:0] line_addr, line_addr_d;
  logic [11:0] sb_d;
  logic [11:0] cnt, cnt_d;
  logic [4:0]  row_d;
  logic [6:0]  col_d;
  logic        wr_en_d;
  logic [11:0] wr_addr_d;
  logic [7:0]  wr_data_d;
  logic        adv;
  logic        nl;
  logic [7:0]  adv_char;
`ifdef TERM_TAB_EN
  logic        tab;
`endif

  function automatic logic [11:0] add_mod(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 13'(N)) s = s - 13'(N);
    return s[11:0];
  endfunction

  function automatic logic is_print(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) state_q <= ST_CLR_ALL;
    else        state_q <= state_d;
  end

  // line_addr tracks (scroll_base + cur_row*term_w) mod N so no multiplier is needed
  always_comb begin
    state_d     = state_q;
    row_d       = cur_row;
    col_d       = cur_col;
    line_addr_d = line_addr;
    sb_d        = scroll_base;
    cnt_d       = cnt;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    adv         = 1'b0;
    nl          = 1'b0;
    adv_char    = blank;
`ifdef TERM_TAB_EN
    tab         = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLR_ALL;
          cnt_d   = '0;
        end else if (in_valid) begin
          if (is_print(in_char)) begin
            adv      = 1'b1;
            adv_char = in_char;
          end else if (in_char == 8'h0A) begin
            nl = 1'b1;
          end else if (in_char == 8'h0D) begin
            col_d = '0;
          end else if (in_char == 8'h08) begin
            if (cur_col != '0) col_d = cur_col - 7'd1;
`ifdef TERM_TAB_EN
          end else if (in_char == 8'h09) begin
            adv = 1'b1;
            tab = 1'b1;
`endif
          end
        end
      end
      ST_CLR_LINE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = line_addr + cnt;
        wr_data_d = blank;
        cnt_d     = cnt + 12'd1;
        if (cnt == W_A - 12'd1) state_d = ST_IDLE;
      end
      ST_CLR_ALL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt;
        wr_data_d = blank;
        cnt_d     = cnt + 12'd1;
        if (cnt == N_M1) begin
          state_d     = ST_IDLE;
          row_d       = '0;
          col_d       = '0;
          line_addr_d = '0;
          sb_d        = '0;
          cnt_d       = '0;
        end
      end
`ifdef TERM_TAB_EN
      ST_TAB: begin
        adv = 1'b1;
        tab = 1'b1;
      end
`endif
      default: state_d = ST_CLR_ALL;
    endcase

    if (adv) begin
      wr_en_d   = 1'b1;
      wr_addr_d = line_addr + {5'd0, cur_col};
      wr_data_d = adv_char;
      if (cur_col < COL_MAX) begin
        col_d = cur_col + 7'd1;
`ifdef TERM_TAB_EN
        if (tab) state_d = (col_d[2:0] == 3'd0) ? ST_IDLE : ST_TAB;
`endif
      end else begin
        nl = 1'b1;
      end
    end

    // At the bottom line the new line_addr equals the old scroll_base, i.e. the line being cleared
    if (nl) begin
      col_d       = '0;
      line_addr_d = add_mod(line_addr, W_A);
      if (cur_row < ROW_MAX) begin
        row_d   = cur_row + 5'd1;
        state_d = ST_IDLE;
      end else begin
        sb_d    = add_mod(scroll_base, W_A);
        cnt_d   = '0;
        state_d = ST_CLR_LINE;
      end
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cur_row     <= '0;
      cur_col     <= '0;
      line_addr   <= '0;
      scroll_base <= '0;
      cnt         <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= blank;
    end else begin
      cur_row     <= row_d;
      cur_col     <= col_d;
      line_addr   <= line_addr_d;
      scroll_base <= sb_d;
      cnt         <= cnt_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
    end
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    in_ready = (state_q == ST_IDLE) && !clr;
  end

endmodule
